nonce_sweeper: RTL
==================

Name: nonce_sweeper

Overview:
Upstream controller for sha256_core, the double-SHA-256 over an 80-byte header. Takes a base block header, a nonce range and a difficulty target. For each nonce it inserts the nonce into the header, issues one hash job to the core, and checks the returned digest against the target. It stops on the first winning nonce, when the range is exhausted, or on abort, and reports the result plus a count of hashes performed.

Parameters:
HDR_W, 640, header width in bits (80 bytes, byte 0 at bits [639:632])
DIG_W, 256, digest and target width in bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; launches a sweep; ignored unless state is IDLE, FOUND or EXHAUSTED
abort  in  1  level; forces a return to IDLE from any non-IDLE state
base_header  in  HDR_W  header template; bits [31:0] are overwritten with the nonce
nonce_start  in  32  first nonce to test
nonce_end  in  32  last nonce to test, inclusive
target  in  DIG_W  difficulty target, big-endian integer
core_header  out  HDR_W  header presented to the core
core_start  out  1  one-cycle job-issue pulse to the core
core_done  in  1  one-cycle pulse from the core; core_digest is valid in the same cycle
core_digest  in  DIG_W  core output, byte 0 at bits [255:248]
busy  out  1  high in ISSUE, WAIT and CHECK
found  out  1  high in FOUND
exhausted  out  1  high in EXHAUSTED
found_nonce  out  32  winning nonce, numeric value
found_digest  out  DIG_W  raw core_digest of the winning nonce
hashes_done  out  32  completed core jobs in the current sweep

Behaviour:
- Reset, applied synchronously in any state:
  - state goes to IDLE.
  - All outputs go to 0: core_header, core_start, busy, found, exhausted, found_nonce, found_digest, hashes_done.
  - Any in-flight core job is abandoned.
- States:
  - IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED.
- start accepted, in IDLE, FOUND or EXHAUSTED:
  - Latch base_header, target, nonce_end.
  - cur_nonce <= nonce_start; clear hashes_done, found, exhausted.
  - If nonce_end < nonce_start, go to EXHAUSTED with hashes_done = 0. Otherwise go to ISSUE.
- ISSUE, one cycle:
  - core_header = {base[639:32], byteswap32(cur_nonce)}.
  - core_start = 1 for exactly this cycle; go to WAIT.
  - core_header holds stable until the next ISSUE.
- WAIT:
  - Remain until core_done; latency is unbounded.
  - On core_done, register core_digest, increment hashes_done, go to CHECK.
- CHECK, one cycle:
  - Compute hashval = byteswap256(digest), i.e. byte 31 becomes the MSB.
  - Win condition is hashval <= target, an unsigned 256-bit compare; equality counts as a win.
  - On a win: found_nonce <= cur_nonce, found_digest <= raw digest, go to FOUND.
  - Else if cur_nonce == nonce_end, go to EXHAUSTED. This check is made before incrementing, so there is no 32-bit wrap and 0xFFFFFFFF is a legal end.
  - Else cur_nonce <= cur_nonce + 1 and go to ISSUE.
  - Issue-to-issue overhead beyond core latency is 2 cycles.
- FOUND and EXHAUSTED:
  - Hold all results until the next accepted start or abort.
- abort, in any non-IDLE state:
  - Go to IDLE next cycle; found and exhausted clear; hashes_done holds.
  - A core_done arriving in IDLE is ignored.
- Simultaneous start and abort: abort wins.
- start outside the accepting states is ignored; no queueing.
- core_done outside WAIT is ignored.

Decomposition:
- Package miner_pkg holds:
  - HDR_W and DIG_W constants.
  - The state enum type.
  - byteswap32 and byteswap256 functions.
  - NONCE_LSB = 0 constant.
- One sub-module, target_compare (combinational byte reversal plus the <= compare), is registered in CHECK. It is reusable by a future multi-core arbiter.

Test Plan:
1. Behavioural core model returning SHA256d with a 20-cycle latency.
   - Stimulus: base = 80-byte header ending in 42a14695 (any low 32 bits), range 0x9546a140..0x9546a150, target 256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d.
   - Required: found = 1, found_nonce = 0x9546a142, found_digest = 256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000, hashes_done = 3, core_header[31:0] = 32'h42a14695.
2. Same as test 1 with target minus 1.
   - Required: exhausted = 1, found = 0, hashes_done = 17, exactly 17 core_start pulses.
3. nonce_start = 0xFFFFFFFE, nonce_end = 0xFFFFFFFF, target = 0.
   - Required: exactly 2 jobs, exhausted, no wrap to nonce 0.
4. nonce_end = 5, nonce_start = 6.
   - Required: exhausted the cycle after start, hashes_done = 0, no core_start.
5. abort asserted mid-WAIT, then a late core_done.
   - Required: IDLE, busy = 0, found = 0, hashes_done unchanged. A following start runs a clean sweep.
6. reset asserted in CHECK, and start pulsed while busy.
   - Required: all outputs 0 on the next edge after reset. The start pulsed while busy is ignored, confirmed by the core_start count.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared definitions for the nonce sweeper and its digest/target comparator.
package miner_pkg;

  localparam int HDR_W     = 640;
  localparam int DIG_W     = 256;
  localparam int NONCE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_FOUND,
    ST_EXHAUSTED
  } sweep_state_e;

  function automatic logic [31:0] byteswap32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic logic [DIG_W-1:0] byteswap256(input logic [DIG_W-1:0] v);
    logic [DIG_W-1:0] r;
    for (int i = 0; i < DIG_W/8; i++) r[8*i +: 8] = v[8*(DIG_W/8-1-i) +: 8];
    return r;
  endfunction

  // The header carries the nonce little-endian in its last four bytes.
  function automatic logic [HDR_W-1:0] insert_nonce(input logic [HDR_W-1:0] hdr,
                                                    input logic [31:0]      nonce);
    logic [HDR_W-1:0] r;
    r = hdr;
    r[NONCE_LSB +: 32] = byteswap32(nonce);
    return r;
  endfunction

endpackage

// File: rtl/target_compare.sv
// Digest-vs-target check: the digest is byte-reversed into a big-endian
// integer and compared unsigned; equality counts as a win.
module target_compare
  import miner_pkg::*;
(
  input  logic [DIG_W-1:0] digest,
  input  logic [DIG_W-1:0] target,
  output logic             win
);

  // Pure combinational compare; the caller registers its inputs.
  always_comb begin
    win = (byteswap256(digest) <= target);
  end

endmodule

// File: rtl/nonce_sweeper.sv
// Walks a nonce range, issuing one double-SHA job per nonce to the hash core
// and stopping on the first digest at or below the target.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   ST_IDLE      | nothing running, results cleared or aborted
//   ST_ISSUE     | core_start pulse for cur_nonce
//   ST_WAIT      | waiting for core_done (unbounded)
//   ST_CHECK     | compare registered digest, advance or stop
//   ST_FOUND     | winning nonce/digest held
//   ST_EXHAUSTED | range finished with no winner
module nonce_sweeper
  import miner_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [HDR_W-1:0] base_header,
  input  logic [31:0]      nonce_start,
  input  logic [31:0]      nonce_end,
  input  logic [DIG_W-1:0] target,
  output logic [HDR_W-1:0] core_header,
  output logic             core_start,
  input  logic             core_done,
  input  logic [DIG_W-1:0] core_digest,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [31:0]      found_nonce,
  output logic [DIG_W-1:0] found_digest,
  output logic [31:0]      hashes_done
);

  sweep_state_e     state_q, state_d;
  logic [HDR_W-1:0] hdr_q;
  logic [DIG_W-1:0] target_q;
  logic [DIG_W-1:0] digest_q;
  logic [31:0]      end_q;
  logic [31:0]      cur_nonce;
  logic             win;
  logic             start_ok;
  logic             empty_range;

  target_compare u_cmp (
    .digest (digest_q),
    .target (target_q),
    .win    (win)
  );

  // Next-state decode; abort overrides everything, including a same-cycle start.
  always_comb begin
    state_d     = state_q;
    empty_range = (nonce_end < nonce_start);
    start_ok    = start && !abort &&
                  (state_q == ST_IDLE || state_q == ST_FOUND || state_q == ST_EXHAUSTED);
    case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (core_done) state_d = ST_CHECK;
      ST_CHECK: begin
        if (win)                     state_d = ST_FOUND;
        else if (cur_nonce == end_q) state_d = ST_EXHAUSTED;
        else                         state_d = ST_ISSUE;
      end
      default: ;
    endcase
    if (start_ok) state_d = empty_range ? ST_EXHAUSTED : ST_ISSUE;
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // State register and sweep datapath; core_header only changes on entry to ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      target_q     <= '0;
      digest_q     <= '0;
      end_q        <= '0;
      cur_nonce    <= '0;
      core_header  <= '0;
      found_nonce  <= '0;
      found_digest <= '0;
      hashes_done  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        hdr_q       <= base_header;
        target_q    <= target;
        end_q       <= nonce_end;
        cur_nonce   <= nonce_start;
        hashes_done <= '0;
        if (!empty_range) core_header <= insert_nonce(base_header, nonce_start);
      end
      if (!abort) begin
        if (state_q == ST_WAIT && core_done) begin
          digest_q    <= core_digest;
          hashes_done <= hashes_done + 32'd1;
        end
        if (state_q == ST_CHECK) begin
          if (win) begin
            found_nonce  <= cur_nonce;
            found_digest <= digest_q;
          end else if (cur_nonce != end_q) begin
            cur_nonce   <= cur_nonce + 32'd1;
            core_header <= insert_nonce(hdr_q, cur_nonce + 32'd1);
          end
        end
      end
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    core_start = (state_q == ST_ISSUE);
    busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    found      = (state_q == ST_FOUND);
    exhausted  = (state_q == ST_EXHAUSTED);
  end

endmodule
